// File: rtl/mem_arb_pkg.sv
// Shared types for the unified I/D memory port arbiter: FSM encoding,
// port identifiers and the access-counter width.
package mem_arb_pkg;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_DM = 2'b10
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (DM) with a
// fixed-latency access counter. Define MEM_ARB_RR_EN for round-robin ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_done_o,
  output logic              stall_if_o,
  output logic              stall_dm_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               done, grant, tie_dm;
  port_e              gport;

`ifdef MEM_ARB_RR_EN
  port_e last_q;
  // Tie goes to whichever port was not granted most recently.
  assign tie_dm = (last_q == PORT_IF);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= PORT_IF;
    else if (grant) last_q <= gport;
  end
`else
  assign tie_dm = 1'b1;
`endif

  assign if_done_o = (state_q == BUSY_IF) && (cnt_q == LAT);
  assign dm_done_o = (state_q == BUSY_DM) && (cnt_q == LAT);
  assign done      = if_done_o | dm_done_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    grant   = 1'b0;
    gport   = PORT_IF;
    case (state_q)
      IDLE: begin
        if (if_req_i && dm_req_i) begin
          grant = 1'b1;
          gport = tie_dm ? PORT_DM : PORT_IF;
        end else if (dm_req_i) begin
          grant = 1'b1;
          gport = PORT_DM;
        end else if (if_req_i) begin
          grant = 1'b1;
          gport = PORT_IF;
        end
      end
      // At the done edge only the other port may be granted, so a held
      // request cannot starve the opposite port.
      BUSY_IF: begin
        if (!done)         cnt_d = cnt_q + 1'b1;
        else if (dm_req_i) begin grant = 1'b1; gport = PORT_DM; end
        else               state_d = IDLE;
      end
      BUSY_DM: begin
        if (!done)         cnt_d = cnt_q + 1'b1;
        else if (if_req_i) begin grant = 1'b1; gport = PORT_IF; end
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      cnt_d = '0;
      if (gport == PORT_DM) begin
        state_d = BUSY_DM;
        addr_d  = dm_addr_i;
        we_d    = dm_we_i;
        wdata_d = dm_wdata_i;
      end else begin
        state_d = BUSY_IF;
        addr_d  = if_addr_i;
        we_d    = 1'b0;
        wdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_en_o    = (state_q != IDLE) && (cnt_q == '0);
  assign mem_we_o    = mem_en_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_done_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_done_o ? mem_rdata_i : '0;
  assign stall_if_o  = if_req_i & ~if_done_o;
  assign stall_dm_o  = dm_req_i & ~dm_done_o;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified instruction/data memory between the pipeline's IF stage (fetch) and MEM stage (load/store). Runs a small FSM with a fixed-latency access counter and produces per-port completion pulses and stall requests. The top level ORs those stall requests into the existing hazard stall network: PC write, IF/ID write and bubble insertion.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch request (level)
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetch data, valid while `if_done`
- `if_done`  out  1  fetch completion pulse
- `dm_req`  in  1  load/store request (level)
- `dm_we`  in  1  1 = store
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_rdata`  out  DATA_W  load data, valid while `dm_done`
- `dm_done`  out  1  data completion pulse
- `stall_if`  out  1  hold PC and IF/ID
- `stall_dm`  out  1  freeze pipeline through EX/MEM
- `mem_en`, `mem_we`  out  1  memory strobe and write enable
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W; `mem_rdata`  in  DATA_W

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM. Counter `cnt` has width 4.
- IDLE transitions:
  - Only `dm_req` high → BUSY_DM.
  - Only `if_req` high → BUSY_IF.
  - Both high → BUSY_DM (tie rule, see Configuration).
  - On entry to a BUSY state: latch address, `we` and `wdata` from the granted port (`we` forced to 0 for IF); set `cnt` to 0.
- BUSY_x: `cnt` increments each cycle. When `cnt == MEM_LAT`, `x_done = 1` and the access ends at that edge.
- Transition out of BUSY_x at the done edge:
  - Other port's `req` high → go directly to BUSY_other and latch its request.
  - Otherwise → IDLE.
  - The serviced port is never re-granted at its own done edge.
- Memory outputs:
  - `mem_en = 1` only in the cycle where BUSY and `cnt == 0`.
  - `mem_addr`, `mem_we` and `mem_wdata` always come from the latch.
  - `mem_we` is gated by `mem_en`.
- Read data: `x_rdata = mem_rdata` while `x_done`, else 0. Stores also pulse `dm_done`.
- Stall outputs (combinational): `stall_if = if_req & ~if_done`; `stall_dm = dm_req & ~dm_done`.
- An accepted access always completes:
  - Dropping `req` or changing address/data mid-access is ignored; the latched values are used.
  - `done` still pulses. The pipeline discards it (e.g. after a branch flush).
- Reset values: state IDLE, `cnt` 0, latches 0, all outputs 0 (except combinational stalls, which follow `req`).

## Timing
- Request in cycle 0, IDLE: accepted at the end of cycle 0. `mem_en` is in cycle 1; `done` is in cycle 1+MEM_LAT.
- Same-port back-to-back: IDLE for one cycle, next `mem_en` in cycle MEM_LAT+3. Throughput is one access per MEM_LAT+2 cycles.
- Cross-port handoff: no idle cycle. The next `mem_en` is the cycle after `done`.
- `rst_n` assertion mid-access:
  - State goes to IDLE immediately; `mem_en`/`done` drop within the cycle.
  - The in-flight access is abandoned and no `done` is produced.
  - After release, pending requests are re-arbitrated at the next edge.

## Configuration
- `MEM_ARB_RR_EN`, defined: register `last_grant` (reset value IF). An IDLE tie goes to the port not in `last_grant`, so the first tie after reset goes to DM and grants alternate on later ties. `last_grant` updates on every grant.
- `MEM_ARB_RR_EN`, undefined: an IDLE tie always goes to DM. No `last_grant` register exists.

## Structure
- Shared package `mem_arb_pkg`:
  - State encoding: IDLE = 2'b00, BUSY_IF = 2'b01, BUSY_DM = 2'b10.
  - Port IDs: PORT_IF = 0, PORT_DM = 1.
  - Counter width constant = 4.
- No sub-module: FSM, counter and latches live in one module.

## Test plan
(All with MEM_LAT = 2.)
- Single fetch: `if_req = 1`, `if_addr = 0x40` in cycle 0 → `mem_en = 1`, `mem_addr = 0x40` in cycle 1; `if_done = 1`, `if_rdata = mem_rdata` in cycle 3; `stall_if` high in cycles 0–2, low in cycle 3.
- Tie (default build): store 0x100 ← 0xDEADBEEF plus fetch 0x44 in cycle 0 → store: `mem_we = 1` in cycle 1, `dm_done` in cycle 3; fetch: `mem_en` in cycle 4, `if_done` in cycle 6.
- `MEM_ARB_RR_EN` build: first tie after reset → DM granted; next tie from IDLE → IF granted.
- `rst_n` low in cycle 2 of a fetch → `mem_en`/`if_done` stay 0, state IDLE. With `if_req` held, re-accept after release with a fresh `mem_en` one cycle later.
- `if_req` dropped in cycle 2 of a fetch → `if_done` still pulses in cycle 3; `stall_if` is 0 from cycle 2.
- Continuous fetches 0x0 then 0x4 → `mem_en` in cycles 1 and 5; `if_done` in cycles 3 and 7.
